// File: rtl/reset_controller_pkg.sv
// Shared definitions for the reset sequencer: state encodings, state width and
// a helper that sizes counters from their terminal count.
package reset_controller_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RST_ST_RST       = 2'd0,
        RST_ST_WAIT_LOCK = 2'd1,
        RST_ST_HOLD      = 2'd2,
        RST_ST_RUN       = 2'd3
    } rst_state_t;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int cnt_width(input int unsigned n);
        if (n <= 1)
            return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/reset_controller_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, debounce (built only when
// RESET_BTN_DEBOUNCE_EN is defined) and a single-cycle press pulse.
module btn_debounce
    import reset_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_btn,
    output logic btn_db,
    output logic press
);

    logic btn_meta;
    logic btn_s;
    logic btn_db_q;
    logic btn_db_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= rst_btn;
            btn_s    <= btn_meta;
        end
    end

`ifdef RESET_BTN_DEBOUNCE_EN
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] btn_cnt;

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_cnt  <= '0;
            btn_db_q <= 1'b0;
        end else if (btn_s == btn_db_q) begin
            btn_cnt  <= '0;
        end else if (btn_cnt == CNT_LAST) begin
            btn_cnt  <= '0;
            btn_db_q <= btn_s;
        end else begin
            btn_cnt  <= btn_cnt + 1'b1;
        end
    end
`else
    localparam int unsigned debounce_cycles_unused = DEBOUNCE_CYCLES;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            btn_db_q <= 1'b0;
        else
            btn_db_q <= btn_s;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            btn_db_prev <= 1'b0;
        else
            btn_db_prev <= btn_db_q;
    end

    assign btn_db = btn_db_q;
    assign press  = btn_db_q & ~btn_db_prev;

endmodule

// File: rtl/reset_controller.sv
// System reset sequencer: waits for clock lock, holds reset for HOLD_CYCLES,
// re-enters reset on lock loss or button press. Option: RESET_BTN_DEBOUNCE_EN.
module reset_controller
    import reset_controller_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               locked,
    input  logic               rst_btn,
    output logic               sys_reset,
    output logic               sys_reset_,
    output logic               ready,
    output logic [STATE_W-1:0] state
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic lock_meta;
    logic lock_s;
    logic press;
    logic btn_db_unused;

    rst_state_t        state_q;
    rst_state_t        state_d;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              sys_reset_q;
    logic              sys_reset_n_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= locked;
            lock_s    <= lock_meta;
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .reset  (reset),
        .rst_btn(rst_btn),
        .btn_db (btn_db_unused),
        .press  (press)
    );

    // Lock loss outranks a press, which outranks hold-counter expiry.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt;
        unique case (state_q)
            RST_ST_RST: begin
                state_d    = RST_ST_WAIT_LOCK;
                hold_cnt_d = '0;
            end
            RST_ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d    = RST_ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            RST_ST_HOLD: begin
                if (!lock_s) begin
                    state_d    = RST_ST_WAIT_LOCK;
                    hold_cnt_d = '0;
                end else if (press) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_d    = RST_ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end
            RST_ST_RUN: begin
                if (!lock_s) begin
                    state_d = RST_ST_WAIT_LOCK;
                end else if (press) begin
                    state_d    = RST_ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = RST_ST_RST;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Reset outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RST_ST_RST;
            hold_cnt      <= '0;
            sys_reset_q   <= 1'b1;
            sys_reset_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt      <= hold_cnt_d;
            sys_reset_q   <= (state_d != RST_ST_RUN);
            sys_reset_n_q <= (state_d == RST_ST_RUN);
        end
    end

    assign sys_reset  = sys_reset_q;
    assign sys_reset_ = sys_reset_n_q;
    assign ready      = (state_q == RST_ST_RUN);
    assign state      = state_q;

endmodule

// File: tb/tb_reset_controller.sv
// Self-checking bench for reset_controller: directed scenarios plus random
// lock/button/reset activity, compared every cycle against a behavioural model.
module tb_reset_controller;

    localparam int HOLD = 16;
    localparam int DEB  = 8;
`ifdef RESET_BTN_DEBOUNCE_EN
    localparam int PRESS_LAT   = DEB;
    localparam int EXP_PRESSES = 1;
`else
    localparam int PRESS_LAT   = 1;
    localparam int EXP_PRESSES = 5;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       locked = 1'b0;
    logic       rst_btn = 1'b0;
    logic       sys_reset;
    logic       sys_reset_;
    logic       ready;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail = 0;
    int press_seen = 0;

    // Behavioural model: phase 0 reset, 1 waiting for lock, 2 holding, 3 running.
    int m_ph;
    int m_edge;
    int m_run_at;
    bit ml1, ml2, mb1, mb2, mdb, mdbd;
    bit m_btn_hist[$];

    always #5 clk = ~clk;

    reset_controller #(
        .HOLD_CYCLES    (HOLD),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .locked    (locked),
        .rst_btn   (rst_btn),
        .sys_reset (sys_reset),
        .sys_reset_(sys_reset_),
        .ready     (ready),
        .state     (state)
    );

    function automatic void model_reset();
        m_ph = 0;
        m_run_at = 0;
        {ml1, ml2, mb1, mb2, mdb, mdbd} = '0;
        m_btn_hist.delete();
    endfunction

    // One clock edge of the model, using the inputs currently applied.
    function automatic void model_edge();
        bit lock_seen = ml2;
        bit press_now = mdb & ~mdbd;
        bit new_db;
        bit all_diff;
        case (m_ph)
            0: m_ph = 1;
            1: if (lock_seen) begin m_ph = 2; m_run_at = m_edge + HOLD; end
            2: begin
                if (!lock_seen) m_ph = 1;
                else if (press_now) m_run_at = m_edge + HOLD;
                else if (m_edge == m_run_at) m_ph = 3;
            end
            default: begin
                if (!lock_seen) m_ph = 1;
                else if (press_now) begin m_ph = 2; m_run_at = m_edge + HOLD; end
            end
        endcase
`ifdef RESET_BTN_DEBOUNCE_EN
        m_btn_hist.push_back(mb2);
        if (m_btn_hist.size() > DEB) void'(m_btn_hist.pop_front());
        all_diff = (m_btn_hist.size() == DEB);
        foreach (m_btn_hist[i]) if (m_btn_hist[i] == mdb) all_diff = 1'b0;
        new_db = all_diff ? ~mdb : mdb;
        if (all_diff) m_btn_hist.delete();
`else
        all_diff = 1'b0;
        new_db = mb2;
`endif
        mdbd = mdb;
        mdb  = new_db;
        ml2  = ml1;
        ml1  = locked;
        mb2  = mb1;
        mb1  = rst_btn;
        m_edge++;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check_output("state", {30'd0, state}, m_ph);
        check_output("sys_reset", {31'd0, sys_reset}, (m_ph != 3) ? 1 : 0);
        check_output("sys_reset_", {31'd0, sys_reset_}, (m_ph == 3) ? 1 : 0);
        check_output("ready", {31'd0, ready}, (m_ph == 3) ? 1 : 0);
    endtask

    // Called at the negedge; advances one clock and checks just after the edge.
    task automatic tick();
        if (reset) model_reset();
        else model_edge();
        if (dut.press === 1'b1) press_seen++;
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Short reset pulse between edges; outputs must react without a clock.
    task automatic async_pulse();
        #1 reset = 1'b1;
        model_reset();
        #1;
        check_output("async_state", {30'd0, state}, 0);
        check_output("async_sys_reset", {31'd0, sys_reset}, 1);
        check_output("async_ready", {31'd0, ready}, 0);
        check_output("async_sys_reset_", {31'd0, sys_reset_}, 0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int n;
        model_reset();
        m_edge = 0;
        #1 reset = 1'b1;
        @(negedge clk);
        check_model();

        // Power-up: reset for 5 cycles, lock arrives at cycle 10.
        repeat (5) tick();
        reset = 1'b0;
        repeat (4) tick();
        locked = 1'b1;
        wait_ready(n);
        check_output("powerup_latency", n, HOLD + 3);

        // One-cycle lock drop while running.
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        tick();
        check_output("lockloss_sys_reset", {31'd0, sys_reset}, 1);
        check_output("lockloss_state", {30'd0, state}, 1);
        wait_ready(n);
        check_output("lockloss_relock", n + 2, HOLD + 3);

        // Bouncing button followed by a steady press, then release.
        press_seen = 0;
        for (int i = 0; i < 30; i++) begin
            rst_btn = ((i / 3) % 2) != 0;
            tick();
        end
        rst_btn = 1'b1;
        repeat (20) tick();
        wait_ready(n);
        check_output("bounce_ready", {31'd0, ready}, 1);
        rst_btn = 1'b0;
        repeat (DEB + 6) tick();
        check_output("bounce_presses", press_seen, EXP_PRESSES);
        check_output("release_no_event", {30'd0, state}, 3);

        // Async reset at hold_cnt = 7.
        locked = 1'b0;
        repeat (3) tick();
        locked = 1'b1;
        n = 0;
        while (state !== 2'd2 && n < 50) begin
            tick();
            n++;
        end
        check_output("reach_hold", {30'd0, state}, 2);
        repeat (7) tick();
        check_output("hold_cnt_7", {28'd0, dut.hold_cnt}, 7);
        async_pulse();
        wait_ready(n);
        check_output("post_reset_full_hold", n, HOLD + 3);

        // Press event and lock loss reach the FSM on the same edge.
        rst_btn = 1'b1;
        repeat (PRESS_LAT) tick();
        locked = 1'b0;
        tick();
        tick();
        check_output("simul_press_pending", {31'd0, dut.press}, 1);
        tick();
        check_output("simul_state", {30'd0, state}, 1);
        locked = 1'b1;
        rst_btn = 1'b0;
        wait_ready(n);
        check_output("simul_recover", {31'd0, ready}, 1);

        // Random lock, button and reset activity.
        for (int i = 0; i < 1500; i++) begin
            if (locked) begin
                if ($urandom_range(39) == 0) locked = 1'b0;
            end else if ($urandom_range(7) == 0) begin
                locked = 1'b1;
            end
            if ($urandom_range(5) == 0) rst_btn = ~rst_btn;
            tick();
            if ($urandom_range(199) == 0) async_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
